// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: PC register and instruction-fetch stage.
// Holds the PC, issues one outstanding request at a time to instruction
// memory and presents the fetched instruction/PC to decode over valid/ready.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module pc_fetch_stage #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_next_i,
    input  logic             pc_sel_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             if_valid_o,
    input  logic             if_ready_i,
    output logic [WIDTH-1:0] if_pc_o,
    output logic [WIDTH-1:0] if_pc_plus4_o,
    output logic [WIDTH-1:0] if_instr_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt_o,
    output logic [31:0]      perf_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             buf_valid_q, buf_valid_d;
    logic [WIDTH-1:0] buf_pc_q, buf_pc_d;
    logic [WIDTH-1:0] buf_instr_q, buf_instr_d;

    logic             consume;
    logic             req;
    logic             fire;
    logic             fill;
    logic [WIDTH-1:0] redirect_pc;

    // Next-state, request and output-buffer control.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fill        = 1'b0;
        consume     = buf_valid_q & if_ready_i;
        // A new request only when the buffer has room for its response;
        // gated by rst_n so nothing is requested while reset is held.
        req         = (state_q == S_REQ) & (~buf_valid_q | consume) & rst_n;
        fire        = req & imem_gnt_i;
        redirect_pc = pc_next_i & ~WIDTH'(3);

        case (state_q)
            S_REQ: begin
                if (fire) state_d = pc_sel_i ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                    if (!pc_sel_i) begin
                        fill = 1'b1;
                        pc_d = pc_q + WIDTH'(4);
                    end
                end else if (pc_sel_i) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // Redirect overrides both the +4 advance and any buffer fill.
        if (pc_sel_i) pc_d = redirect_pc;

        buf_valid_d = buf_valid_q & ~consume;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        if (fill) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = pc_q;
            buf_instr_d = imem_rdata_i;
        end
        if (pc_sel_i) buf_valid_d = 1'b0;
    end

    // State, PC and output-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign if_valid_o    = buf_valid_q;
    assign if_pc_o       = buf_pc_q;
    assign if_pc_plus4_o = buf_pc_q + WIDTH'(4);
    assign if_instr_o    = buf_valid_q ? buf_instr_q : NOP_INSTR;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    // Count accepted instructions and cycles stalled by decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (buf_valid_q & if_ready_i)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (buf_valid_q & ~if_ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Testbench for pc_fetch_stage: directed scenarios plus randomized traffic,
// checked against a transaction-level scoreboard of the fetch stage.
module tb_pc_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_next_i;
    logic        pc_sel_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus4_o;
    logic [31:0] if_instr_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_stall_cnt_o;
`endif

    pc_fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_next_i    (pc_next_i),
        .pc_sel_i     (pc_sel_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_ready_i   (if_ready_i),
        .if_pc_o      (if_pc_o),
        .if_pc_plus4_o(if_pc_plus4_o),
        .if_instr_o   (if_instr_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o(perf_fetch_cnt_o),
        .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus controls for the next step
    logic        rst_v   = 1'b0;
    logic        sel_v   = 1'b0;
    logic [31:0] next_v  = '0;
    logic        ready_v = 1'b1;
    logic        gallow_v = 1'b0;
    int          fix_lat = 0;
    logic        fix_data_en = 1'b0;
    logic [31:0] fix_data = '0;

    // instruction memory model
    logic        mem_pend = 1'b0;
    int          mem_rv_cyc = 0;
    logic [31:0] mem_data = '0;
    int          cyc = 0;

    // scoreboard: expected fetch PC, outstanding transaction, decode buffer
    logic [31:0] exp_pc  = RESET_PC;
    logic        m_out   = 1'b0;
    logic        m_stale = 1'b0;
    logic [31:0] m_addr  = '0;
    logic        m_bv    = 1'b0;
    logic [31:0] m_bpc   = RESET_PC;
    logic [31:0] m_bin   = NOP_INSTR;
    logic [31:0] m_fcnt  = '0;
    logic [31:0] m_scnt  = '0;

    // sampled DUT outputs of the latest step
    logic        s_req, s_valid, s_gnt;
    logic [31:0] s_addr, s_pc, s_p4, s_instr;

    initial begin
        rst_n = 1'b0; pc_next_i = '0; pc_sel_i = 1'b0; imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0; if_ready_i = 1'b1;
    end

    // One clock cycle: drive inputs at negedge, sample, score, advance models.
    task automatic step();
        logic rv, gnt, cons, resp_ok, exp_req;
        logic [31:0] cur_pc;
        int lat;
        @(negedge clk);
        rst_n      = rst_v;
        pc_sel_i   = sel_v;
        pc_next_i  = next_v;
        if_ready_i = ready_v;
        rv = mem_pend && (cyc == mem_rv_cyc);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_data : $urandom;
        gnt = gallow_v && (!mem_pend || rv);
        imem_gnt_i = gnt;
        #1;
        s_req = imem_req_o; s_addr = imem_addr_o; s_valid = if_valid_o; s_gnt = gnt;
        s_pc = if_pc_o; s_p4 = if_pc_plus4_o; s_instr = if_instr_o;

        if (!rst_v) begin
            exp_pc = RESET_PC; m_out = 1'b0; m_stale = 1'b0; m_bv = 1'b0;
            m_bpc = RESET_PC; m_fcnt = '0; m_scnt = '0;
        end

        exp_req = rst_v && !m_out && (!m_bv || ready_v);
        n_tests++;
        if (s_req !== exp_req) begin
            n_fail++; $display("FAIL sb_req cyc=%0d got %b exp %b", cyc, s_req, exp_req);
        end
        if (s_req && exp_req) begin
            n_tests++;
            if (s_addr !== exp_pc) begin
                n_fail++; $display("FAIL sb_addr cyc=%0d got %h exp %h", cyc, s_addr, exp_pc);
            end
        end
        n_tests++;
        if (s_valid !== m_bv) begin
            n_fail++; $display("FAIL sb_valid cyc=%0d got %b exp %b", cyc, s_valid, m_bv);
        end
        n_tests++;
        if (s_instr !== (m_bv ? m_bin : NOP_INSTR)) begin
            n_fail++; $display("FAIL sb_instr cyc=%0d got %h exp %h", cyc, s_instr, m_bv ? m_bin : NOP_INSTR);
        end
        if (m_bv || !rst_v) begin
            n_tests++;
            if (s_pc !== m_bpc || s_p4 !== m_bpc + 32'd4) begin
                n_fail++; $display("FAIL sb_pc cyc=%0d got %h/%h exp %h/%h", cyc, s_pc, s_p4, m_bpc, m_bpc + 32'd4);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        n_tests++;
        if (perf_fetch_cnt_o !== m_fcnt || perf_stall_cnt_o !== m_scnt) begin
            n_fail++; $display("FAIL sb_perf cyc=%0d got %0d/%0d exp %0d/%0d", cyc, perf_fetch_cnt_o, perf_stall_cnt_o, m_fcnt, m_scnt);
        end
`endif

        if (rst_v) begin
            cur_pc = exp_pc;
            cons = m_bv && ready_v;
            if (cons) m_fcnt = m_fcnt + 32'd1;
            if (m_bv && !ready_v) m_scnt = m_scnt + 32'd1;
            resp_ok = 1'b0;
            if (rv && m_out) begin
                resp_ok = !m_stale && !sel_v;
                m_out = 1'b0;
            end else if (m_out && sel_v) begin
                m_stale = 1'b1;
            end
            if (cons) m_bv = 1'b0;
            if (resp_ok) begin
                m_bv = 1'b1; m_bpc = m_addr; m_bin = imem_rdata_i; exp_pc = m_addr + 32'd4;
            end
            if (sel_v) begin
                m_bv = 1'b0; exp_pc = next_v & ~32'd3;
            end
            if (s_req && gnt) begin
                m_out = 1'b1; m_addr = cur_pc; m_stale = sel_v;
            end
        end

        if (rv) mem_pend = 1'b0;
        if (s_req && gnt) begin
            lat = (fix_lat != 0) ? fix_lat : 1 + int'($urandom_range(0, 2));
            mem_pend   = 1'b1;
            mem_rv_cyc = cyc + lat;
            mem_data   = fix_data_en ? fix_data : $urandom;
        end
        cyc++;
    endtask

    task automatic apply_reset();
        rst_v = 1'b0; sel_v = 1'b0; gallow_v = 1'b0;
        step(); step();
        for (int i = 0; i < 10 && mem_pend; i++) step();
        rst_v = 1'b1; ready_v = 1'b1; fix_lat = 1; fix_data_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_v = 1'b0; gallow_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (s_req !== 1'b0 || s_valid !== 1'b0 || s_pc !== RESET_PC || s_instr !== NOP_INSTR) begin
                n_fail++; $display("FAIL reset_state got req=%b v=%b pc=%h in=%h exp 0/0/%h/%h", s_req, s_valid, s_pc, s_instr, RESET_PC, NOP_INSTR);
            end
        end
        gallow_v = 1'b0;
    endtask

    task automatic test_basic_fetch();
        logic [31:0] addrs [3];
        int na = 0, first_v = -1;
        apply_reset();
        gallow_v = 1'b1; fix_data_en = 1'b1; fix_data = 32'h0010_0093;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_req && s_gnt && na < 3) begin addrs[na] = s_addr; na++; end
            if (s_valid && first_v < 0) begin
                first_v = i;
                n_tests++;
                if (s_pc !== 32'h0 || s_instr !== 32'h0010_0093 || s_p4 !== 32'h4) begin
                    n_fail++; $display("FAIL first_fetch got %h/%h/%h exp 0/00100093/4", s_pc, s_instr, s_p4);
                end
            end
        end
        n_tests++;
        if (first_v != 2) begin
            n_fail++; $display("FAIL first_latency got %0d exp 2", first_v);
        end
        n_tests++;
        if (na != 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
            n_fail++; $display("FAIL addr_seq got n=%0d %h %h %h exp 3 0 4 8", na, addrs[0], addrs[1], addrs[2]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hpc, hin;
        int k;
        apply_reset();
        gallow_v = 1'b1; ready_v = 1'b0;
        for (k = 0; k < 10 && !s_valid; k++) step();
        n_tests++;
        if (!s_valid) begin n_fail++; $display("FAIL bp_valid_timeout got 0 exp 1"); end
        hpc = s_pc; hin = s_instr;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (s_valid !== 1'b1 || s_pc !== hpc || s_instr !== hin || s_req !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold got v=%b %h %h req=%b exp 1 %h %h 0", s_valid, s_pc, s_instr, s_req, hpc, hin);
            end
        end
        ready_v = 1'b1;
        step();
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h4 || s_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_release got req=%b addr=%h pc=%h exp 1 4 0", s_req, s_addr, s_pc);
        end
    endtask

    task automatic test_redirect_wait();
        int reqs = 0;
        logic [31:0] a = '0;
        apply_reset();
        gallow_v = 1'b1; fix_lat = 4; fix_data_en = 1'b1; fix_data = 32'hDEAD_BEEF;
        step();
        fix_data_en = 1'b0; fix_lat = 1;
        sel_v = 1'b1; next_v = 32'h0000_0200;
        step();
        sel_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (s_valid && s_instr === 32'hDEAD_BEEF) begin
                n_fail++; $display("FAIL stale_presented got %h exp not DEADBEEF", s_instr);
            end
            if (s_req && reqs == 0) begin reqs = i + 1; a = s_addr; end
        end
        n_tests++;
        if (reqs != 4 || a !== 32'h200) begin
            n_fail++; $display("FAIL redirect_wait got step=%0d addr=%h exp 4 200", reqs, a);
        end
    endtask

    task automatic test_redirect_rvalid();
        apply_reset();
        gallow_v = 1'b1;
        step();
        sel_v = 1'b1; next_v = 32'h0000_0103;
        step();
        n_tests++;
        if (imem_rvalid_i !== 1'b1) begin n_fail++; $display("FAIL redir_rv_setup got %b exp 1", imem_rvalid_i); end
        sel_v = 1'b0;
        step();
        n_tests++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h100 || s_instr !== NOP_INSTR) begin
            n_fail++; $display("FAIL redirect_rvalid got v=%b req=%b addr=%h in=%h exp 0 1 100 %h", s_valid, s_req, s_addr, s_instr, NOP_INSTR);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        gallow_v = 1'b0; sel_v = 1'b1; next_v = 32'hFFFF_FFFC;
        step();
        sel_v = 1'b0; gallow_v = 1'b1;
        step();
        n_tests++;
        if (s_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr got %h exp fffffffc", s_addr); end
        step(); step();
        n_tests++;
        if (s_valid !== 1'b1 || s_pc !== 32'hFFFF_FFFC || s_p4 !== 32'h0 || s_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap got v=%b pc=%h p4=%h addr=%h exp 1 fffffffc 0 0", s_valid, s_pc, s_p4, s_addr);
        end
    endtask

    task automatic test_async_reset();
        int k;
        apply_reset();
        gallow_v = 1'b1; fix_lat = 5; fix_data_en = 1'b1; fix_data = 32'hCAFE_F00D;
        step();
        gallow_v = 1'b0; fix_data_en = 1'b0; fix_lat = 1;
        step();
        #2 rst_n = 1'b0; rst_v = 1'b0;
        #1;
        n_tests++;
        if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0 || if_pc_o !== RESET_PC || if_instr_o !== NOP_INSTR) begin
            n_fail++; $display("FAIL async_reset got req=%b v=%b pc=%h in=%h exp 0 0 %h %h", imem_req_o, if_valid_o, if_pc_o, if_instr_o, RESET_PC, NOP_INSTR);
        end
        step(); step();
        rst_v = 1'b1; gallow_v = 1'b1;
        for (k = 0; k < 12 && !s_valid; k++) step();
        n_tests++;
        if (s_valid !== 1'b1 || s_pc !== RESET_PC || s_instr === 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL restart got v=%b pc=%h in=%h exp 1 %h not cafef00d", s_valid, s_pc, s_instr, RESET_PC);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        int k, cons = 0;
        apply_reset();
        gallow_v = 1'b1; ready_v = 1'b0;
        for (k = 0; k < 10 && !s_valid; k++) step();
        step();
        ready_v = 1'b1;
        for (k = 0; k < 40 && cons < 3; k++) begin
            step();
            if (s_valid) cons++;
            if (cons == 2) gallow_v = 1'b0;
        end
        step();
        n_tests++;
        if (perf_fetch_cnt_o !== 32'd3 || perf_stall_cnt_o !== 32'd2) begin
            n_fail++; $display("FAIL perf got %0d/%0d exp 3/2", perf_fetch_cnt_o, perf_stall_cnt_o);
        end
    endtask
`endif

    task automatic test_random();
        apply_reset();
        fix_lat = 0;
        for (int i = 0; i < 800; i++) begin
            ready_v  = ($urandom_range(0, 3) != 0);
            gallow_v = ($urandom_range(0, 3) != 0);
            sel_v    = ($urandom_range(0, 9) == 0);
            next_v   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            step();
        end
        sel_v = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- PC register and instruction-fetch stage of the RV32 core.
- Sits directly downstream of the next-PC mux2: consumes its output (pc_next_i) when a redirect is signalled, otherwise advances PC by 4.
- Issues one-outstanding requests to instruction memory and presents fetched instruction/PC to decode over a valid/ready handshake.

Parameters:
- WIDTH, 32, address/data width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, value of if_instr_o while not valid (addi x0,x0,0)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- pc_next_i  input  WIDTH  redirect target from next-PC mux2 output
- pc_sel_i  input  1  redirect strobe (branch taken / jump / trap); 1 = load pc_next_i
- imem_req_o  output  1  fetch request
- imem_addr_o  output  WIDTH  fetch address (word aligned)
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  response valid (≥1 cycle after gnt)
- imem_rdata_i  input  WIDTH  response instruction
- if_valid_o  output  1  fetched instruction valid to decode
- if_ready_i  input  1  decode accepts
- if_pc_o  output  WIDTH  PC of presented instruction
- if_pc_plus4_o  output  WIDTH  if_pc_o + 4, modulo 2^WIDTH
- if_instr_o  output  WIDTH  presented instruction

Behaviour:
- Reset (rst_n=0, immediate): pc_q=RESET_PC, state=S_REQ, drop flag=0, imem_req_o=0, if_valid_o=0, if_pc_o=RESET_PC, if_instr_o=NOP_INSTR.
- imem_req_o is forced 0 while rst_n=0. The first request (addr RESET_PC) is issued in the first cycle after release.
- States:
  - S_REQ: imem_req_o=1, imem_addr_o=pc_q, but only when the output buffer is empty or being consumed (if_valid_o & if_ready_i); otherwise imem_req_o=0. On gnt -> S_WAIT.
  - S_WAIT: imem_req_o=0. On imem_rvalid_i: buffer <= {pc_q, imem_rdata_i}, if_valid_o=1 next cycle, pc_q <= pc_q+4, -> S_REQ.
  - S_DROP: waiting for a stale response. On imem_rvalid_i: discard, -> S_REQ.
- Handshake: the buffer is consumed when if_valid_o & if_ready_i. While if_valid_o=1 & if_ready_i=0, if_pc_o/if_instr_o are held stable. Buffer and new fill in the same cycle: new data wins, if_valid_o stays 1.
- Latency: gnt same cycle as req, rvalid 1 cycle later -> if_valid_o 1 cycle after rvalid. Peak throughput is 1 instr / 2 cycles.
- Redirect (pc_sel_i=1), priority over +4:
  - Every state: pc_q <= pc_next_i & ~3 (bits[1:0] forced 0); output buffer invalidated (if_valid_o=0 next cycle, if_instr_o=NOP_INSTR).
  - S_REQ, no gnt: request address changes to the new PC next cycle; stay S_REQ.
  - S_REQ with gnt same cycle: old request is stale -> S_DROP.
  - S_WAIT, no rvalid: -> S_DROP.
  - S_WAIT with rvalid same cycle: data discarded -> S_REQ.
  - S_DROP: stay S_DROP until the stale rvalid arrives.
- Redirect concurrent with consume: consume is accepted, buffer is still cleared.
- imem_rvalid_i in S_REQ (e.g. after reset mid-transaction): ignored.
- Wrap: pc_q 32'hFFFF_FFFC + 4 -> 32'h0000_0000. if_pc_plus4_o wraps identically.
- All arithmetic is unsigned WIDTH-bit. Carry is discarded.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt_o [31:0] (increments on each if_valid_o & if_ready_i) and perf_stall_cnt_o [31:0] (increments each cycle if_valid_o & ~if_ready_i). Both reset to 0, wrap at 2^32, and are unaffected by redirect.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset release, gnt immediate, rvalid 1 cycle later with data 32'h0010_0093, if_ready_i=1 -> imem_addr_o sequence 0,4,8. First if_valid_o with if_pc_o=0, if_instr_o=32'h0010_0093, if_pc_plus4_o=4.
- Backpressure: if_ready_i=0 for 5 cycles after first valid -> if_pc_o/if_instr_o stable, imem_req_o=0. Release -> next fetch at 4.
- Redirect in S_WAIT: pc_sel_i=1, pc_next_i=32'h0000_0200, stale rvalid 3 cycles later with 32'hDEAD_BEEF -> never presented. Next imem_addr_o=32'h200.
- Redirect same cycle as rvalid, target 32'h0000_0103 -> response dropped, next imem_addr_o=32'h100, if_valid_o=0.
- Wrap: redirect to 32'hFFFF_FFFC, one fetch -> if_pc_plus4_o=0, next imem_addr_o=0.
- Async reset asserted in S_WAIT mid-transaction -> imem_req_o/if_valid_o drop immediately. Late rvalid ignored. Fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN: 3 consumes + 2 stall cycles -> counters read 3 and 2.
